// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared state, record type and width helper for the carry-chain TDC channel
package tdc_pkg;

  // Widest coarse and fine fields any legal channel can produce (TAPS <= 256).
  localparam int COARSE_MAX_W = 32;
  localparam int FINE_MAX_W   = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DEAD    = 2'd3
  } tdc_state_e;

  typedef struct packed {
    logic                    sat;
    logic [COARSE_MAX_W-1:0] coarse;
    logic [FINE_MAX_W-1:0]   fine;
  } tdc_rec_t;

  // Bits needed to hold a tap count of 0..taps inclusive.
  function automatic int fine_w(input int taps);
    return $clog2(taps + 1);
  endfunction

endpackage

// File: rtl/tdc_therm_encoder.sv
// rtl/tdc_therm_encoder.sv - bubble-corrected thermometer to tap-count encoder
module tdc_therm_encoder import tdc_pkg::*; #(
  parameter int TAPS   = 64,
  parameter int FINE_W = fine_w(TAPS)
) (
  input  logic [TAPS-1:0]   therm,
  output logic [FINE_W-1:0] fine,
  output logic              sat,
  output logic              first_tap
);

  // Pad with a virtual 1 below tap 0 and a virtual 0 above the last tap.
  logic [TAPS+1:0] padded;
  logic [TAPS-1:0] corr;

  assign padded = {1'b0, therm, 1'b1};

  // Three-tap majority vote removes single-tap bubbles.
  always_comb begin
    corr = '0;
    for (int i = 0; i < TAPS; i++) begin
      corr[i] = (padded[i] & padded[i+1]) | (padded[i] & padded[i+2]) | (padded[i+1] & padded[i+2]);
    end
  end

  // Fine time is the number of corrected taps the hit has reached.
  always_comb begin
    fine = '0;
    for (int i = 0; i < TAPS; i++) begin
      fine = fine + FINE_W'(corr[i]);
    end
  end

  assign sat       = &corr;
  assign first_tap = corr[0];

endmodule

// File: rtl/tdc_carry_channel.sv
// rtl/tdc_carry_channel.sv - one TDC channel: carry-chain sampling, event FSM and result FIFO
module tdc_carry_channel import tdc_pkg::*; #(
  parameter int TAPS       = 64,
  parameter int COARSE_W   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DEAD_CYC   = 4,
  parameter int EXT_TAPS   = 0
) (
  input  logic                            clock,
  input  logic                            aclr_n,
  input  logic                            hit,
  input  logic [TAPS-1:0]                 taps_ext,
  input  logic                            enable,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [COARSE_W+fine_w(TAPS):0]  out_data,
  output logic [7:0]                      drop_cnt,
  output logic                            busy
);

  localparam int FINE_W = fine_w(TAPS);
  localparam int REC_W  = 1 + COARSE_W + FINE_W;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam int DW     = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  logic [1:0]          rst_sync;
  logic                rst_n;
  logic [TAPS-1:0]     chain_taps, a_op, b_op, taps;
  logic [TAPS-1:0]     s1, s2;
  logic [COARSE_W-1:0] coarse_cnt, coarse_s1, coarse_s2;
  logic [FINE_W-1:0]   fine;
  logic                sat, first_tap, first_q, hit_event, dead_done;
  tdc_state_e          state;
  logic [DW-1:0]       dead_cnt;
  tdc_rec_t            rec_q;
  logic                unused_rec;
  logic [REC_W-1:0]    rec_flat, head_q;
  logic [REC_W-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]       rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0]       count, count_left;
  logic                empty, full, capture, push, pop, drop;

  // Assert asynchronously, release two clocks later so nothing sees a runt release.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Carry chain with a = ones and b = zero: every stage propagates the hit.
  assign a_op = '1;
  assign b_op = '0;
  always_comb begin : carry_chain
    logic carry;
    chain_taps = '0;
    carry      = hit;
    for (int i = 0; i < TAPS; i++) begin
      carry         = (a_op[i] & b_op[i]) | ((a_op[i] ^ b_op[i]) & carry);
      chain_taps[i] = carry;
    end
  end
  assign taps = (EXT_TAPS != 0) ? taps_ext : chain_taps;

  // Metastability pair on the taps, coarse time delayed alongside so both describe edge k.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= '0;
      s2         <= '0;
      coarse_cnt <= '0;
      coarse_s1  <= '0;
      coarse_s2  <= '0;
      first_q    <= 1'b0;
    end else begin
      s1         <= taps;
      s2         <= s1;
      coarse_cnt <= coarse_cnt + COARSE_W'(1);
      coarse_s1  <= coarse_cnt;
      coarse_s2  <= coarse_s1;
      first_q    <= first_tap;
    end
  end

  tdc_therm_encoder #(.TAPS(TAPS), .FINE_W(FINE_W)) u_enc (
    .therm     (s2),
    .fine      (fine),
    .sat       (sat),
    .first_tap (first_tap)
  );

  assign hit_event = (state == ST_ARMED) && first_tap && !first_q;
  assign dead_done = (dead_cnt == DW'(DEAD_CYC - 1));

  // Channel FSM; the record is latched on the event and written from CAPTURE.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      dead_cnt <= '0;
      rec_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (enable) state <= ST_ARMED;
        ST_ARMED: begin
          if (hit_event) begin
            state       <= ST_CAPTURE;
            rec_q.sat    <= sat;
            rec_q.coarse <= COARSE_MAX_W'(coarse_s2);
            rec_q.fine   <= FINE_MAX_W'(fine);
          end else if (!enable) begin
            state <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          state    <= ST_DEAD;
          dead_cnt <= '0;
        end
        ST_DEAD: begin
          if (dead_done) begin
            if (!enable)         state <= ST_IDLE;
            else if (!first_tap) state <= ST_ARMED;
          end else begin
            dead_cnt <= dead_cnt + DW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state != ST_IDLE);
  assign rec_flat   = {rec_q.sat, rec_q.coarse[COARSE_W-1:0], rec_q.fine[FINE_W-1:0]};
  assign unused_rec = ^rec_q;

  assign empty      = (count == '0);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign capture    = (state == ST_CAPTURE);
  assign pop        = !empty && out_ready;
  assign push       = capture && (!full || pop);
  assign drop       = capture && full && !pop;
  assign count_left = count - CW'(pop);
  assign rd_next    = rd_ptr + AW'(pop);

  // Entry storage needs no reset; validity lives in the pointers.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= rec_flat;
  end

  // Pointers, drop counter and a registered head that holds its value once drained.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      head_q   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      count  <= count_left + CW'(push);
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (count_left == '0) begin
        if (push) head_q <= rec_flat;
      end else begin
        head_q <= mem[rd_next];
      end
    end
  end

  assign out_valid = !empty;
  assign out_data  = head_q;

endmodule

// File: tb/tb_tdc_carry_channel.sv
// tb/tb_tdc_carry_channel.sv - self-checking bench for tdc_carry_channel
module tb_tdc_carry_channel;

  localparam int TAPS = 16;

  logic        clock = 1'b0;
  logic        aclr_n = 1'b1;
  logic        hit = 1'b0;
  logic [15:0] taps_ext = '0;
  logic        enable = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [13:0] out_data;
  logic [7:0]  drop_cnt;
  logic        busy;

  always #5 clock = ~clock;

  tdc_carry_channel #(
    .TAPS(16), .COARSE_W(8), .FIFO_DEPTH(4), .DEAD_CYC(4), .EXT_TAPS(1)
  ) dut (
    .clock     (clock),
    .aclr_n    (aclr_n),
    .hit       (hit),
    .taps_ext  (taps_ext),
    .enable    (enable),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the channel should have produced, by edge number.
  typedef struct {
    int          due;
    logic [13:0] rec;
  } pend_t;

  pend_t       pend[$];
  logic [13:0] q[$];
  logic [13:0] last_data = '0;
  logic [7:0]  m_coarse = '0;
  int          rel_edges = 0;
  int          edge_no = 0;
  int          m_drop = 0;
  bit          m_prev_c0 = 1'b0;
  bit          model_armed = 1'b0;
  logic [15:0] taps_cur = '0;
  bit          ready_cur = 1'b0;

  function automatic logic [15:0] correct(input logic [15:0] t);
    logic [17:0] e;
    logic [15:0] c;
    e = {1'b0, t, 1'b1};
    for (int i = 0; i < TAPS; i++) c[i] = (int'(e[i]) + int'(e[i+1]) + int'(e[i+2])) >= 2;
    return c;
  endfunction

  function automatic logic [13:0] rec_of(input logic [15:0] t, input logic [7:0] cs);
    logic [15:0] c;
    c = correct(t);
    return {c == 16'hFFFF, cs, 5'($countones(c))};
  endfunction

  task automatic model_edge();
    logic [15:0] c;
    bit pop, full_before;
    edge_no++;
    c = correct(taps_cur);
    if (c[0] && !m_prev_c0 && model_armed)
      pend.push_back('{due: edge_no + 3, rec: rec_of(taps_cur, m_coarse)});
    m_prev_c0 = c[0];
    full_before = (q.size() == 4);
    pop = (q.size() > 0) && ready_cur;
    if (pop) begin
      last_data = q[0];
      void'(q.pop_front());
    end
    if (pend.size() > 0 && pend[0].due == edge_no) begin
      if (full_before && !pop) begin
        if (m_drop < 255) m_drop++;
      end else begin
        q.push_back(pend[0].rec);
      end
      void'(pend.pop_front());
    end
    rel_edges++;
    if (rel_edges >= 3) m_coarse = m_coarse + 8'd1;
  endtask

  task automatic check_outputs();
    check_eq("valid", out_valid, q.size() > 0);
    check_eq("data", out_data, (q.size() > 0) ? q[0] : last_data);
    check_eq("drop", drop_cnt, m_drop);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic set_taps(input logic [15:0] t);
    taps_ext = t;
    taps_cur = t;
  endtask

  task automatic set_ready(input bit r);
    out_ready = r;
    ready_cur = r;
  endtask

  task automatic fire(input logic [15:0] t, output logic [7:0] cs);
    cs = m_coarse;
    set_taps(t);
    step();
    set_taps('0);
    repeat (3) step();
  endtask

  task automatic drain();
    set_ready(1'b1);
    repeat (8) step();
    set_ready(1'b0);
  endtask

  task automatic do_reset();
    aclr_n = 1'b0;
    #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_drop", drop_cnt, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_data", out_data, 0);
    q.delete();
    pend.delete();
    m_drop = 0;
    last_data = '0;
    m_coarse = '0;
    rel_edges = 0;
    m_prev_c0 = 1'b0;
    model_armed = 1'b0;
    repeat (2) @(negedge clock);
    aclr_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  cs, cs2;
    logic [13:0] exp_rec[6];
    logic [15:0] t;
    int          n, h, g;

    #2;
    do_reset();
    enable = 1'b1;
    repeat (8) step();
    check_eq("busy_armed", busy, 1);
    model_armed = 1'b1;

    // First record: fixed latency and content.
    while (m_coarse != 8'h10) step();
    set_taps(16'h003F);
    step();
    set_taps('0);
    step();
    step();
    check_eq("lat_k2_valid", out_valid, 0);
    step();
    check_eq("lat_k3_valid", out_valid, 1);
    check_eq("first_rec", out_data, {1'b0, 8'h10, 5'd6});
    drain();

    // Bubble correction and saturation.
    fire(16'h005F, cs);
    check_eq("bubble_fine", out_data[4:0], 6);
    check_eq("bubble_sat", out_data[13], 0);
    drain();
    fire(16'hFFFF, cs);
    check_eq("full_sat", out_data[13], 1);
    check_eq("full_fine", out_data[4:0], 16);
    drain();

    // Coarse wrap across two events ten cycles apart.
    while (m_coarse != 8'hFF) step();
    fire(16'h0007, cs);
    check_eq("wrap_ff", out_data[12:5], 8'hFF);
    repeat (6) step();
    fire(16'h000F, cs2);
    set_ready(1'b1);
    step();
    set_ready(1'b0);
    check_eq("wrap_09", out_data[12:5], 8'h09);
    drain();

    // Backpressure: four held, two dropped, head stable, then in-order drain.
    for (int i = 0; i < 6; i++) begin
      t = 16'((32'd1 << (i + 2)) - 1);
      fire(t, cs);
      exp_rec[i] = rec_of(t, cs);
      check_eq("hold_head", out_data, exp_rec[0]);
      repeat (4) step();
    end
    check_eq("drop_two", drop_cnt, 2);
    set_ready(1'b1);
    for (int i = 0; i < 4; i++) begin
      check_eq("pop_order", out_data, exp_rec[i]);
      step();
    end
    check_eq("drained", out_valid, 0);

    // Long hit: one record, FSM parked in DEAD until taps clear.
    set_taps(16'h0003);
    repeat (10) step();
    check_eq("dead_hold_busy", busy, 1);
    set_taps('0);
    repeat (6) step();
    fire(16'h000F, cs);
    repeat (6) step();
    set_taps(16'h0003);
    repeat (10) step();
    enable = 1'b0;
    model_armed = 1'b0;
    repeat (6) step();
    check_eq("idle_busy", busy, 0);
    set_taps('0);
    repeat (4) step();
    fire(16'h0007, cs);
    check_eq("idle_ignored", out_valid, 0);
    enable = 1'b1;
    repeat (4) step();
    model_armed = 1'b1;

    // Randomized events with random backpressure against the model.
    for (int ev = 0; ev < 150; ev++) begin
      n = $urandom_range(1, 16);
      t = (n == 16) ? 16'hFFFF : 16'((32'd1 << n) - 1);
      if ($urandom_range(0, 2) == 0) t = t ^ 16'(32'd1 << $urandom_range(0, 15));
      t[0] = 1'b1;
      h = $urandom_range(1, 3);
      g = $urandom_range(6, 12);
      set_taps(t);
      for (int j = 0; j < h + g; j++) begin
        if (j == h) set_taps('0);
        set_ready($urandom_range(0, 2) == 0);
        step();
      end
    end

    // Reset with entries queued.
    drain();
    fire(16'h0003, cs);
    repeat (4) step();
    fire(16'h001F, cs);
    check_eq("two_queued", out_valid, 1);
    enable = 1'b0;
    do_reset();
    repeat (6) step();
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_valid", out_valid, 0);
    enable = 1'b1;
    repeat (6) step();
    model_armed = 1'b1;
    fire(16'h00FF, cs);
    check_eq("post_rst_rec", out_data, rec_of(16'h00FF, cs));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdc_carry_channel.md
TDC_CARRY_CHANNEL -- requirements
Module: tdc_carry_channel

Interface
REQ-001 Parameter TAPS, default 64: delay-line length in carry-chain taps, legal range 8..256.
REQ-002 Parameter COARSE_W, default 16: width of the coarse cycle counter.
REQ-003 Parameter FIFO_DEPTH, default 8: number of result entries buffered, power of two.
REQ-004 Parameter DEAD_CYC, default 4: minimum number of cycles the channel stays re-arm-blocked after each event.
REQ-005 Parameter EXT_TAPS, default 0: 1 selects taps_ext instead of the internal chain (verification only).
REQ-006 clock  input  1  the only clock; all state is rising-edge triggered.
REQ-007 aclr_n  input  1  asynchronous, active-low reset.
REQ-008 hit  input  1  asynchronous hit; drives cin of the internal CARRY_CHAIN (a = all ones, b = 0, width = TAPS).
REQ-009 taps_ext  input  TAPS  external thermometer taps, used only when EXT_TAPS = 1; bit i = 1 means the hit has reached tap i.
REQ-010 enable  input  1  arms the channel when high.
REQ-011 out_valid  output  1  the FIFO head is valid.
REQ-012 out_ready  input  1  the consumer accepts the head when high with out_valid.
REQ-013 out_data  output  1+COARSE_W+FINE_W  {sat, coarse, fine}, FINE_W = clog2(TAPS+1).
REQ-014 drop_cnt  output  8  saturating count of events lost because the FIFO was full.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 Taps shall be captured into stage s1 at edge k and into s2 at edge k+1 (metastability pair); no logic between them.
REQ-017 Bubble correction on s2: c[i] = majority(s2[i-1], s2[i], s2[i+1]), with s2[-1] = 1 and s2[TAPS] = 0.
REQ-018 fine = popcount(c), range 0..TAPS; sat = 1 when c is all ones (fine = TAPS).
REQ-019 Coarse counter: free-running, increments every cycle, wraps 2^COARSE_W-1 -> 0; the recorded coarse is the counter value present at sample edge k.
REQ-020 Event: c[0] = 1 while the previous-cycle c[0] = 0, evaluated only in ARMED; {sat, coarse, fine} registered at edge k+2.
REQ-021 FSM states and transitions:
- IDLE -> ARMED when enable = 1.
- ARMED -> CAPTURE on an event.
- CAPTURE -> DEAD after 1 cycle (FIFO write).
- DEAD -> ARMED when DEAD_CYC cycles have elapsed and c[0] = 0, if enable = 1; otherwise DEAD -> IDLE.
REQ-022 FIFO write occurs at edge k+3; out_valid rises after edge k+3 when the FIFO was empty (total latency 3 cycles sample-to-valid).
REQ-023 Pop occurs when out_valid and out_ready are both high; out_data shall stay stable while out_valid = 1 and out_ready = 0.
REQ-024 Full FIFO with no pop in the same cycle: the record is dropped and drop_cnt increments, saturating at 255; full with a pop in the same cycle: push and pop both occur.
REQ-025 Empty FIFO: out_valid = 0 and out_data holds its last value; a simultaneous push into an empty FIFO is not bypassed.
REQ-026 enable deasserted in CAPTURE or DEAD: the current record completes, then the FSM enters IDLE; events in IDLE are ignored.
REQ-027 A hit still propagating when DEAD ends (c[0] = 1) holds the FSM in DEAD; no re-trigger is possible on the same edge.

Reset
REQ-028 aclr_n = 0 shall asynchronously clear s1, s2, the coarse counter, the FSM (to IDLE), the FIFO pointers, drop_cnt, out_valid and busy to 0, with out_data = 0; release is synchronised internally with a 2-flop synchroniser.
REQ-029 Reset asserted mid-operation discards in-flight records and buffered entries, with no partial output.

Structure
REQ-030 Package tdc_pkg shall hold the FSM state enum, the FINE_W function, and the record struct {sat, coarse, fine}.
REQ-031 Sub-module tdc_therm_encoder shall perform bubble correction, popcount and sat (combinational, TAPS-parametrised); the FIFO is inline in tdc_carry_channel.

Verification (TAPS = 16, COARSE_W = 8, FIFO_DEPTH = 4, DEAD_CYC = 4, EXT_TAPS = 1)
REQ-032 enable = 1, taps_ext 0x0000 -> 0x003F at coarse = 0x10 -> out_valid 3 cycles later with sat = 0, coarse = 0x10, fine = 6.
REQ-033 Bubble: taps_ext = 0x005F -> fine = 6 (bit 5 filled, bit 6 removed); taps_ext = 0xFFFF -> sat = 1, fine = 16.
REQ-034 Coarse wrap: event sampled at coarse = 0xFF -> record coarse = 0xFF; the next event 10 cycles later -> coarse = 0x09.
REQ-035 out_ready = 0, 6 events spaced 8 cycles apart -> 4 entries held, drop_cnt = 2, out_data stable; then out_ready = 1 -> 4 pops in order.
REQ-036 Taps held at 0x0003 for 10 cycles -> exactly 1 record, FSM stays in DEAD until taps clear; enable dropped in DEAD -> IDLE, busy = 0.
REQ-037 aclr_n pulsed low with 2 entries queued -> out_valid = 0 immediately, drop_cnt = 0, the FSM in IDLE after release.
